// File: rtl/wb_uart_rx.sv
// UART 8-N-1 receiver that oversamples the line, checks the start and stop bits, and pushes good bytes over a pipelined Wishbone push port.
// Sticky framing-error and overrun flags are cleared by a CPU strobe.
module wb_uart_rx #(
  parameter int CLKS_PER_BIT = 16,
  parameter int CNT_W        = 8
) (
  input  logic       i_clk,
  input  logic       i_reset_n,
  input  logic       uart_rx,
  output logic       o_wb_push_fifo_stb,
  output logic       o_wb_push_fifo_cyc,
  output logic [7:0] o_wb_push_fifo_data,
  input  logic       i_wb_push_fifo_ack,
  input  logic       i_wb_push_fifo_stall,
  input  logic       i_err_clr_stb,
  output logic       o_frame_err,
  output logic       o_overrun,
  output logic       o_busy
);

  localparam logic [CNT_W-1:0] HALF_LOAD = CNT_W'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CNT_W-1:0] BIT_LOAD  = CNT_W'(CLKS_PER_BIT - 1);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_START = 3'd1,
    S_DATA  = 3'd2,
    S_STOP  = 3'd3,
    S_BREAK = 3'd4
  } state_t;

  state_t           state_q,     state_d;
  logic             sync1_q,     sync1_d;
  logic             rx_s_q,      rx_s_d;
  logic [CNT_W-1:0] cnt_q,       cnt_d;
  logic [2:0]       bit_idx_q,   bit_idx_d;
  logic [7:0]       shreg_q,     shreg_d;
  logic [7:0]       hold_q,      hold_d;
  logic             pending_q,   pending_d;
  logic             stb_q,       stb_d;
  logic             cyc_q,       cyc_d;
  logic             frame_err_q, frame_err_d;
  logic             overrun_q,   overrun_d;

  logic sample;
  logic byte_good;
  logic ferr_set;
  logic ovr_set;

  always_comb begin
    sync1_d     = uart_rx;
    rx_s_d      = sync1_q;
    state_d     = state_q;
    cnt_d       = cnt_q;
    bit_idx_d   = bit_idx_q;
    shreg_d     = shreg_q;
    hold_d      = hold_q;
    pending_d   = pending_q;
    stb_d       = stb_q;
    cyc_d       = cyc_q;
    byte_good   = 1'b0;
    ferr_set    = 1'b0;
    ovr_set     = 1'b0;
    sample      = (cnt_q == '0);

    if (!sample) begin
      cnt_d = cnt_q - CNT_W'(1);
    end

    case (state_q)
      S_IDLE: begin
        if (!rx_s_q) begin
          state_d = S_START;
          cnt_d   = HALF_LOAD;
        end
      end
      S_START: begin
        if (sample) begin
          if (!rx_s_q) begin
            state_d   = S_DATA;
            cnt_d     = BIT_LOAD;
            bit_idx_d = 3'd0;
          end else begin
            state_d = S_IDLE;
          end
        end
      end
      S_DATA: begin
        if (sample) begin
          shreg_d = {rx_s_q, shreg_q[7:1]};
          cnt_d   = BIT_LOAD;
          if (bit_idx_q == 3'd7) begin
            state_d = S_STOP;
          end else begin
            bit_idx_d = bit_idx_q + 3'd1;
          end
        end
      end
      S_STOP: begin
        if (sample) begin
          if (rx_s_q) begin
            byte_good = 1'b1;
            state_d   = S_IDLE;
          end else begin
            ferr_set = 1'b1;
            state_d  = S_BREAK;
          end
        end
      end
      S_BREAK: begin
        if (rx_s_q) begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase

    // Push handshake: stb ends on acceptance, cyc and pending end on ack.
    if (stb_q && !i_wb_push_fifo_stall) begin
      stb_d = 1'b0;
    end
    if (cyc_q && i_wb_push_fifo_ack) begin
      stb_d     = 1'b0;
      cyc_d     = 1'b0;
      pending_d = 1'b0;
    end

    // Overrun is judged on the registered pending, so an ack in this same cycle still counts.
    if (byte_good) begin
      if (!pending_q) begin
        hold_d    = shreg_q;
        pending_d = 1'b1;
        stb_d     = 1'b1;
        cyc_d     = 1'b1;
      end else begin
        ovr_set = 1'b1;
      end
    end

    frame_err_d = ferr_set | (frame_err_q & ~i_err_clr_stb);
    overrun_d   = ovr_set  | (overrun_q   & ~i_err_clr_stb);
  end

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      state_q     <= S_IDLE;
      sync1_q     <= 1'b1;
      rx_s_q      <= 1'b1;
      cnt_q       <= '0;
      bit_idx_q   <= 3'd0;
      shreg_q     <= 8'h00;
      hold_q      <= 8'h00;
      pending_q   <= 1'b0;
      stb_q       <= 1'b0;
      cyc_q       <= 1'b0;
      frame_err_q <= 1'b0;
      overrun_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      sync1_q     <= sync1_d;
      rx_s_q      <= rx_s_d;
      cnt_q       <= cnt_d;
      bit_idx_q   <= bit_idx_d;
      shreg_q     <= shreg_d;
      hold_q      <= hold_d;
      pending_q   <= pending_d;
      stb_q       <= stb_d;
      cyc_q       <= cyc_d;
      frame_err_q <= frame_err_d;
      overrun_q   <= overrun_d;
    end
  end

  assign o_wb_push_fifo_stb  = stb_q;
  assign o_wb_push_fifo_cyc  = cyc_q;
  assign o_wb_push_fifo_data = hold_q;
  assign o_frame_err         = frame_err_q;
  assign o_overrun           = overrun_q;
  assign o_busy              = (state_q != S_IDLE);

endmodule

// File: tb/tb_wb_uart_rx.sv
// Bench for wb_uart_rx: directed frame table, hand-written corner sequences, and random frames checked against a queue model.
module tb_wb_uart_rx;
  localparam int CPB = 16;

  logic       clk     = 1'b0;
  logic       rst_n   = 1'b0;
  logic       uart_rx = 1'b1;
  logic       ack     = 1'b0;
  logic       stall   = 1'b0;
  logic       err_clr = 1'b0;
  logic       stb, cyc, ferr, ovr, busy;
  logic [7:0] data;

  always #5 clk = ~clk;

  wb_uart_rx #(.CLKS_PER_BIT(CPB), .CNT_W(8)) dut (
    .i_clk               (clk),
    .i_reset_n           (rst_n),
    .uart_rx             (uart_rx),
    .o_wb_push_fifo_stb  (stb),
    .o_wb_push_fifo_cyc  (cyc),
    .o_wb_push_fifo_data (data),
    .i_wb_push_fifo_ack  (ack),
    .i_wb_push_fifo_stall(stall),
    .i_err_clr_stb       (err_clr),
    .o_frame_err         (ferr),
    .o_overrun           (ovr),
    .o_busy              (busy)
  );

  int         n_pass  = 0;
  int         n_total = 0;
  logic [7:0] got[$];
  int         stb_cycles = 0;
  bit         ack_next   = 1'b0;

  // FIFO model: accepts when stb is seen with stall low, acks one cycle later.
  initial begin
    forever begin
      @(posedge clk);
      #2;
      ack      = ack_next;
      ack_next = 1'b0;
      if (stb) stb_cycles++;
      if (stb && !stall) begin
        got.push_back(data);
        ack_next = 1'b1;
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input int act, input int exp);
    n_total++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", name, act, exp);
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic clear_errs();
    err_clr = 1'b1;
    tick(1);
    err_clr = 1'b0;
  endtask

  task automatic send_start_data(input logic [7:0] d);
    uart_rx = 1'b0;
    tick(CPB);
    for (int i = 0; i < 8; i++) begin
      uart_rx = d[i];
      tick(CPB);
    end
  endtask

  task automatic send_frame(input logic [7:0] d, input bit stop);
    send_start_data(d);
    uart_rx = stop;
    tick(CPB);
    uart_rx = 1'b1;
  endtask

  typedef struct {
    logic [7:0] d;
    bit         stop;
    int         exp_push;
    logic [7:0] exp_data;
    bit         exp_ferr;
  } vec_t;

  vec_t       vecs[6];
  logic [7:0] exp_q[$];

  initial begin
    int         base;
    int         sc;
    bit         ferr_m;
    logic [7:0] rd;
    bit         rok;
    int         gap;

    vecs[0] = '{8'hA5, 1'b1, 1, 8'hA5, 1'b0};
    vecs[1] = '{8'h3C, 1'b0, 0, 8'h00, 1'b1};
    vecs[2] = '{8'h11, 1'b1, 1, 8'h11, 1'b0};
    vecs[3] = '{8'h00, 1'b1, 1, 8'h00, 1'b0};
    vecs[4] = '{8'hFF, 1'b1, 1, 8'hFF, 1'b0};
    vecs[5] = '{8'h5A, 1'b1, 1, 8'h5A, 1'b0};

    tick(3);
    check("rst_stb",  stb,  0);
    check("rst_cyc",  cyc,  0);
    check("rst_data", data, 0);
    check("rst_ferr", ferr, 0);
    check("rst_ovr",  ovr,  0);
    check("rst_busy", busy, 0);
    rst_n = 1'b1;
    tick(4);

    for (int v = 0; v < 6; v++) begin
      clear_errs();
      base = got.size();
      sc   = stb_cycles;
      send_frame(vecs[v].d, vecs[v].stop);
      tick(4);
      check($sformatf("vec%0d_npush", v), got.size() - base, vecs[v].exp_push);
      if (vecs[v].exp_push == 1 && got.size() > base)
        check($sformatf("vec%0d_data", v), got[base], vecs[v].exp_data);
      check($sformatf("vec%0d_stbcyc", v), stb_cycles - sc, vecs[v].exp_push);
      check($sformatf("vec%0d_ferr", v), ferr, vecs[v].exp_ferr);
      check($sformatf("vec%0d_ovr", v), ovr, 0);
      check($sformatf("vec%0d_busy", v), busy, 0);
    end

    // Glitch: a 4-cycle low pulse must not be taken as a start bit.
    clear_errs();
    tick(4);
    base    = got.size();
    uart_rx = 1'b0;
    tick(4);
    check("glitch_busy_hi", busy, 1);
    uart_rx = 1'b1;
    tick(8);
    check("glitch_busy_lo", busy, 0);
    tick(CPB * 10);
    check("glitch_npush", got.size() - base, 0);
    check("glitch_ferr", ferr, 0);
    check("glitch_ovr", ovr, 0);

    // Framing error with line held low, then a good frame.
    base = got.size();
    send_start_data(8'h3C);
    uart_rx = 1'b0;
    tick(40);
    check("break_busy", busy, 1);
    check("break_ferr", ferr, 1);
    uart_rx = 1'b1;
    tick(4);
    check("break_exit", busy, 0);
    check("break_npush", got.size() - base, 0);
    send_frame(8'h11, 1'b1);
    tick(4);
    check("after_break_npush", got.size() - base, 1);
    if (got.size() > base) check("after_break_data", got[base], 8'h11);
    clear_errs();
    check("ferr_cleared", ferr, 0);

    // Overrun: second byte arrives while the first is stalled.
    base  = got.size();
    stall = 1'b1;
    send_frame(8'h01, 1'b1);
    send_frame(8'h02, 1'b1);
    tick(2);
    check("ovr_set", ovr, 1);
    check("ovr_stb_held", stb, 1);
    check("ovr_npush_stalled", got.size() - base, 0);
    stall = 1'b0;
    tick(6);
    check("ovr_npush", got.size() - base, 1);
    if (got.size() > base) check("ovr_data", got[base], 8'h01);
    tick(CPB * 2);
    check("ovr_npush_late", got.size() - base, 1);
    clear_errs();
    check("ovr_cleared", ovr, 0);

    // Back-to-back frames with no idle gap.
    base = got.size();
    send_frame(8'h00, 1'b1);
    send_frame(8'hFF, 1'b1);
    tick(4);
    check("b2b_npush", got.size() - base, 2);
    if (got.size() >= base + 2) begin
      check("b2b_data0", got[base], 8'h00);
      check("b2b_data1", got[base + 1], 8'hFF);
    end

    // Asynchronous reset mid-frame with a stalled push outstanding.
    stall = 1'b1;
    send_frame(8'h77, 1'b1);
    tick(2);
    check("mid_rst_stb_pre", stb, 1);
    uart_rx = 1'b0;
    tick(CPB);
    for (int i = 0; i < 4; i++) begin
      uart_rx = i[0];
      tick(CPB);
    end
    tick(CPB / 2);
    #2;
    rst_n = 1'b0;
    #1;
    check("mid_rst_stb",  stb,  0);
    check("mid_rst_cyc",  cyc,  0);
    check("mid_rst_busy", busy, 0);
    check("mid_rst_data", data, 0);
    tick(2);
    stall   = 1'b0;
    uart_rx = 1'b1;
    rst_n   = 1'b1;
    tick(4);
    base = got.size();
    send_frame(8'h5A, 1'b1);
    tick(4);
    check("post_rst_npush", got.size() - base, 1);
    if (got.size() > base) check("post_rst_data", got[base], 8'h5A);

    // Random frames against a queue model.
    clear_errs();
    base   = got.size();
    ferr_m = 1'b0;
    exp_q.delete();
    for (int f = 0; f < 24; f++) begin
      rd  = 8'($urandom_range(0, 255));
      rok = ($urandom_range(0, 4) != 0);
      gap = $urandom_range(0, 3);
      if (!rok && gap == 0) gap = 1;
      send_frame(rd, rok);
      if (rok) exp_q.push_back(rd);
      else ferr_m = 1'b1;
      check($sformatf("rand%0d_cnt", f), got.size() - base, exp_q.size());
      if (gap > 0) tick(gap * CPB);
    end
    tick(4);
    check("rand_total", got.size() - base, exp_q.size());
    for (int i = 0; i < exp_q.size(); i++) begin
      if (base + i < got.size())
        check($sformatf("rand_data%0d", i), got[base + i], exp_q[i]);
    end
    check("rand_ferr", ferr, ferr_m);
    check("rand_ovr", ovr, 0);
    check("rand_busy", busy, 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule

// File: doc/wb_uart_rx.md
# wb_uart_rx

UART receive front end: oversamples the asynchronous `uart_rx` line, validates start and stop bits, and assembles 8-N-1 frames LSB-first. Each good byte is pushed into the RX FIFO over the same pipelined Wishbone push interface that the TX path uses toward its FIFO. Framing and overrun errors are flagged as sticky status for the CPU-side register block. Baud timing is generated internally from a clocks-per-bit divider, so no external clock divider or shifter is needed.

## Interface
- `CLKS_PER_BIT`, default 16: `i_clk` cycles per UART bit. Must be an even number ≥ 4.
- `CNT_W`, default 8: width of the bit-timing down-counter. Must satisfy `CLKS_PER_BIT-1 < 2**CNT_W`.
- `i_clk`, in, 1: system clock. This is the only clock.
- `i_reset_n`, in, 1: asynchronous, active-low reset.
- `uart_rx`, in, 1: serial line. Idle level is 1.
- `o_wb_push_fifo_stb`, out, 1: push request strobe.
- `o_wb_push_fifo_cyc`, out, 1: push cycle.
- `o_wb_push_fifo_data`, out, 8: received byte.
- `i_wb_push_fifo_ack`, in, 1: FIFO write acknowledge.
- `i_wb_push_fifo_stall`, in, 1: FIFO not accepting (full).
- `i_err_clr_stb`, in, 1: one-cycle strobe that clears both error flags.
- `o_frame_err`, out, 1: sticky. A stop bit was sampled as 0.
- `o_overrun`, out, 1: sticky. A byte was dropped because the previous push was still pending.
- `o_busy`, out, 1: high whenever the FSM is not in IDLE.

## Operation
- **Synchronizer:** 2-FF synchronizer on `uart_rx`, both stages reset to 1. All FSM decisions use the second stage, `rx_s`.
- **Counter:** down-counter `cnt` (`CNT_W` bits). Every "sample" below happens in the cycle where `cnt == 0`.
- **Bit index:** `bit_idx`, 3 bits.
- **Shift register:** `shreg`, 8 bits. Each data sample does `shreg <= {rx_s, shreg[7:1]}`, so data arrives LSB-first.

FSM states:
- **IDLE:** when `rx_s == 0`, go to START and load `cnt = CLKS_PER_BIT/2 - 1`.
- **START:** at sample:
  - `rx_s == 0`: go to DATA, load `cnt = CLKS_PER_BIT-1`, set `bit_idx = 0`.
  - `rx_s == 1`: false start (glitch). Return to IDLE; no flags are set.
- **DATA:** at sample, shift in `rx_s` and reload `cnt = CLKS_PER_BIT-1`.
  - If `bit_idx == 7`, go to STOP.
  - Otherwise increment `bit_idx`.
- **STOP:** at sample:
  - `rx_s == 1`: the byte is good; go to IDLE. If `pending == 0`, load `hold <= shreg` and set `pending = 1`. Otherwise discard the byte and set `o_overrun`.
  - `rx_s == 0`: set `o_frame_err`, push nothing, go to BREAK.
- **BREAK:** stay until `rx_s == 1`, then go to IDLE. This prevents a held-low line from being decoded as repeated 0x00 frames.
- **Illegal encodings:** any state encoding outside the five above goes to IDLE on the next cycle.

Push handshake (runs independently of the FSM):
- `o_wb_push_fifo_data = hold`.
- `o_wb_push_fifo_stb` and `o_wb_push_fifo_cyc` are registered. Both rise the cycle after `pending` is set.
- `stb` stays high until it is sampled high together with `!i_wb_push_fifo_stall`. It drops the following cycle.
- `cyc` stays high until `i_wb_push_fifo_ack`. On that cycle `cyc` drops next cycle and `pending` clears.
- A new byte can be accepted in the same cycle that `pending` clears.

Error flags:
- `o_frame_err` and `o_overrun` clear on `i_err_clr_stb`.
- If a set and a clear occur in the same cycle, the set wins.

## Timing
- **Reset values:** stb=0, cyc=0, data=0x00, frame_err=0, overrun=0, busy=0. FSM in IDLE, pending=0, sync FFs=1.
- **Reset is asynchronous.** Asserting it mid-frame or mid-push drops `stb`/`cyc` immediately and discards any partial byte.
- **Sample points:** let `t0` be the first cycle in which IDLE sees `rx_s == 0`.
  - Start sample: `t0 + CLKS_PER_BIT/2`.
  - Data bit k: `t0 + CLKS_PER_BIT/2 + (k+1)*CLKS_PER_BIT`.
  - Stop sample: `t0 + CLKS_PER_BIT/2 + 9*CLKS_PER_BIT`.
- **Push latency:** `stb` is high at stop sample + 1.
- **Synchronizer latency:** 2 cycles from the pin to `rx_s`.
- **Next frame:** back-to-back frames work because IDLE is re-entered at mid-stop bit, so a start edge arriving half a bit later is detected.
- **Overrun boundary:** a byte completing while `pending == 1`, including the cycle in which `ack` arrives, counts as overrun. It counts only if `pending` is still set at the STOP sample cycle.

## Test plan
- **Single byte:** 0xA5 at 16 clk/bit, stall=0, ack one cycle after stb → exactly one push with data 0xA5; stb high 1 cycle; no flags.
- **Glitch:** `uart_rx` low for 4 cycles, then high → returns to IDLE; no push; flags 0; busy drops by `t0+8`.
- **Framing error:** frame 0x3C with stop bit 0, line held low 40 cycles, then high → frame_err=1; no push; FSM waits in BREAK until the line is high. A following frame 0x11 pushes 0x11.
- **Overrun:** stall held high across frames 0x01 and 0x02, then released → 0x01 is pushed after stall drops, 0x02 is never pushed, overrun=1. `i_err_clr_stb` clears it.
- **Back-to-back:** frames 0x00 then 0xFF, no idle gap, prompt acks → two pushes, 0x00 then 0xFF.
- **Reset mid-frame:** assert `i_reset_n=0` during data bit 4 → all outputs reset immediately. After release, frame 0x5A pushes 0x5A.
